mm_job_sched: RTL

Round-robin job scheduler that shares one `front_end`-controlled accelerator between `NCH` requesters. It arbitrates among pending jobs and latches the winner's beat count. It then drives `start`/`done` into the front end, counting its `en` and `wr` strobes to decide when the job has fully drained. It sits between the per-channel host/DMA command logic and the single front end, and it also steers the input/output FIFO muxes via a one-hot select.

---
 rtl/mm_job_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mm_job_sched.sv
// mm_job_sched
// Round-robin job scheduler that shares one front-end-controlled accelerator
// between NCH requesters. A winner is picked among pending requests. Its beat
// count is latched, and the scheduler then drives start/done into the front end.
// It counts the front end's en/wr strobes to detect when the job has fully
// drained, and acknowledges (or aborts) the job.
//
// Ports:
//   aclk      in   clock, rising edge
//   aresetn   in   asynchronous active-low reset
//   req       in   [NCH]     level request per channel, held until ack
//   len       in   [NCH*LW]  job length per channel, sampled at grant
//   ack       out  [NCH]     one-cycle completion pulse to the granted channel
//   abort     out            one-cycle pulse when a running job is dropped
//   busy      out            high whenever not idle
//   grant_id  out  [IW]      index of the granted channel, held while idle
//   sel       out  [NCH]     one-hot FIFO mux select, nonzero only while running
//   fe_start  out            front end start
//   fe_done   out            front end done
//   fe_en     in             front end consumed one beat
//   fe_wr     in             front end wrote one result
module mm_job_sched #(
    parameter  int NCH = 4,
    parameter  int LW  = 16,
    localparam int IW  = $clog2(NCH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*LW-1:0] len,
    output logic [NCH-1:0]    ack,
    output logic              abort,
    output logic              busy,
    output logic [IW-1:0]     grant_id,
    output logic [NCH-1:0]    sel,
    output logic              fe_start,
    output logic              fe_done,
    input  logic              fe_en,
    input  logic              fe_wr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q,  grant_d;
    logic [LW-1:0]   len_q,    len_d;
    logic [LW-1:0]   en_cnt_q, en_cnt_d;
    logic [LW-1:0]   wr_cnt_q, wr_cnt_d;

    logic [IW-1:0]   pick;
    logic [LW-1:0]   pick_len;

    // First requesting channel at or after ptr, searching upward with wrap.
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] r,
                                              input logic [IW-1:0]  ptr);
        logic [IW-1:0] win;
        int            idx;
        win = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (r[idx[IW-1:0]]) win = idx[IW-1:0];
        end
        return win;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (g == IW'(NCH - 1)) ? '0 : g + IW'(1);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            en_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            en_cnt_q <= en_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // The latched length is only consulted while running, after a grant has
    // loaded it, so it needs no reset.
    always_ff @(posedge aclk) begin
        len_q <= len_d;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        len_d    = len_q;
        en_cnt_d = en_cnt_q;
        wr_cnt_d = wr_cnt_q;

        pick     = rr_pick(req, rr_ptr_q);
        pick_len = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick == IW'(i)) pick_len = len[i*LW +: LW];
        end

        ack      = '0;
        abort    = 1'b0;
        busy     = (state_q != ST_IDLE);
        grant_id = grant_q;
        sel      = '0;
        fe_start = 1'b0;
        fe_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d  = pick;
                    len_d    = pick_len;
                    en_cnt_d = '0;
                    wr_cnt_d = '0;
                    // A zero-length job skips the front end entirely.
                    state_d  = (pick_len != '0) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RUN: begin
                fe_start = 1'b1;
                sel      = NCH'(1) << grant_q;
                fe_done  = (en_cnt_q == len_q);
                if (fe_en && (en_cnt_q != len_q)) en_cnt_d = en_cnt_q + LW'(1);
                if (fe_wr && (wr_cnt_q != len_q)) wr_cnt_d = wr_cnt_q + LW'(1);
                // A dropped request wins over a job that completes this cycle.
                if (!req[grant_q]) begin
                    state_d = ST_DROP;
                end else if (wr_cnt_q == len_q) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                fe_done  = 1'b1;
                ack      = NCH'(1) << grant_q;
                rr_ptr_d = next_ptr(grant_q);
                state_d  = ST_IDLE;
            end
            ST_DROP: begin
                abort    = 1'b1;
                rr_ptr_d = next_ptr(grant_q);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
